// File: rtl/fifo_rd_prefetch.sv
// Read-side pointer control and 2-entry output prefetch buffer for the async FIFO.
// Define FIFO_RD_GRAY_EN when the pointers cross a clock boundary in Gray code.
module fifo_rd_prefetch #(
   parameter int DW = 18,
   parameter int AW = 7
) (
   input  logic          rclk,
   input  logic          rrst_n,
   input  logic [AW:0]   wr_ptr_in,
   output logic [AW:0]   rd_ptr_out,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          idle
);

   logic [AW:0]   rd_ptr;
   logic [AW:0]   wr_bin;
   logic [AW:0]   ptr_enc;
   logic          inflight;
   logic [1:0]    cnt;
   logic          head;
   logic          wr_idx;
   logic [DW-1:0] buf_q [2];
   logic          empty;
   logic          pop;
   logic          issue;
   logic [1:0]    occ_next;

`ifdef FIFO_RD_GRAY_EN
   always_comb begin
      wr_bin = '0;
      for (int i = 0; i <= AW; i++) begin
         wr_bin[i] = ^(wr_ptr_in >> i);
      end
   end

   assign ptr_enc = rd_ptr ^ (rd_ptr >> 1);
`else
   assign wr_bin  = wr_ptr_in;
   assign ptr_enc = rd_ptr;
`endif

   assign empty = (rd_ptr == wr_bin);
   assign pop   = m_valid & m_ready;

   // Words held or arriving after this edge; the in-flight word is always captured next edge.
   assign occ_next = cnt + 2'(inflight) - 2'(pop);
   assign issue    = !empty && (occ_next < 2'd2);

   // Tail slot is head offset by cnt, modulo the two entries.
   assign wr_idx = head ^ cnt[0];

   assign rd_addr = rd_ptr[AW-1:0];
   assign m_valid = (cnt != 2'd0);
   assign m_data  = buf_q[head];
   assign idle    = empty && !inflight && (cnt == 2'd0);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rd_ptr     <= '0;
         rd_ptr_out <= '0;
         inflight   <= 1'b0;
      end else begin
         if (issue) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         inflight   <= issue;
         rd_ptr_out <= ptr_enc;
      end
   end

   // NOTE: the two buffer words are reset too, so m_data reads 0 out of reset
   // rather than stale data; a deeper RAM-style buffer would not be reset.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         head     <= 1'b0;
         cnt      <= 2'd0;
      end else begin
         if (inflight) begin
            buf_q[wr_idx] <= rd_data;
         end
         if (pop) begin
            head <= ~head;
         end
         cnt <= occ_next;
      end
   end

   a_no_overflow : assert property (@(posedge rclk) disable iff (!rrst_n)
      !(inflight && (cnt == 2'd2)));

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Directed self-checking bench for fifo_rd_prefetch with a registered-read RAM model.
// Expected pointer encodings follow FIFO_RD_GRAY_EN when it is defined.
module tb_fifo_rd_prefetch;

   localparam int DW = 18;
   localparam int AW = 7;

   logic          rclk = 1'b0;
   logic          rrst_n;
   logic [AW:0]   wr_ptr_in;
   logic [AW:0]   rd_ptr_out;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          idle;

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wptr;
   int            tests = 0;
   int            fails = 0;

   fifo_rd_prefetch #(.DW(DW), .AW(AW)) dut (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .wr_ptr_in  (wr_ptr_in),
      .rd_ptr_out (rd_ptr_out),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .idle       (idle)
   );

   always #5 rclk = ~rclk;

   always @(posedge rclk) rd_data <= mem[rd_addr];

   function automatic logic [AW:0] enc(input logic [AW:0] b);
`ifdef FIFO_RD_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   task automatic push(input logic [DW-1:0] d);
      mem[wptr[AW-1:0]] = d;
      wptr      = wptr + (AW+1)'(1);
      wr_ptr_in = enc(wptr);
   endtask

   // Holds m_ready high; expects n words base, base+1, ... on consecutive cycles.
   task automatic consume(input logic [DW-1:0] base, input int n, output int waited);
      logic [DW-1:0] exp_d;
      waited = 0;
      while (!m_valid && waited < 16) begin
         @(negedge rclk);
         waited++;
      end
      tests++;
      if (m_valid !== 1'b1) begin
         fails++;
         $display("FAIL consume_start: m_valid=%b after %0d cycles, required 1", m_valid, waited);
         return;
      end
      for (int i = 0; i < n; i++) begin
         exp_d = base + DW'(i);
         tests++;
         if (m_valid !== 1'b1 || m_data !== exp_d) begin
            fails++;
            $display("FAIL stream_word[%0d]: m_valid=%b m_data=%h, required 1/%h",
                     i, m_valid, m_data, exp_d);
         end
         @(negedge rclk);
      end
   endtask

   task automatic test_reset;
      rrst_n    = 1'b0;
      m_ready   = 1'b1;
      wptr      = '0;
      wr_ptr_in = '0;
      repeat (3) @(negedge rclk);
      tests++;
      if (m_valid !== 1'b0 || m_data !== '0) begin
         fails++;
         $display("FAIL reset_out: m_valid=%b m_data=%h, required 0/0", m_valid, m_data);
      end
      tests++;
      if (rd_ptr_out !== '0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL reset_ptr: rd_ptr_out=%h idle=%b, required 0/1", rd_ptr_out, idle);
      end
      rrst_n = 1'b1;
      repeat (3) @(negedge rclk);
      tests++;
      if (m_valid !== 1'b0 || rd_addr !== '0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL reset_release: m_valid=%b rd_addr=%h idle=%b, required 0/0/1",
                  m_valid, rd_addr, idle);
      end
   endtask

   task automatic test_single;
      push(DW'(18'h155));
      @(negedge rclk);
      tests++;
      if (rd_addr !== 7'd1 || m_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_issue: rd_addr=%h m_valid=%b, required 1/0", rd_addr, m_valid);
      end
      @(negedge rclk);
      tests++;
      if (m_valid !== 1'b1 || m_data !== DW'(18'h155)) begin
         fails++;
         $display("FAIL single_data: m_valid=%b m_data=%h, required 1/155", m_valid, m_data);
      end
      tests++;
      if (rd_ptr_out !== enc(8'd1)) begin
         fails++;
         $display("FAIL single_ptr: rd_ptr_out=%h, required %h", rd_ptr_out, enc(8'd1));
      end
      @(negedge rclk);
      tests++;
      if (m_valid !== 1'b0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL single_pop: m_valid=%b idle=%b, required 0/1", m_valid, idle);
      end
   endtask

   task automatic test_streaming;
      int waited;
      for (int i = 0; i < 128; i++) push(DW'(i));
      consume('0, 128, waited);
      tests++;
      if (waited != 2) begin
         fails++;
         $display("FAIL stream_latency: %0d cycles, required 2", waited);
      end
      tests++;
      if (m_valid !== 1'b0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL stream_drain: m_valid=%b idle=%b, required 0/1", m_valid, idle);
      end
   endtask

   task automatic test_backpressure;
      int waited;
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) push(DW'(18'h200 + i));
      repeat (2) @(negedge rclk);
      for (int c = 0; c < 8; c++) begin
         tests++;
         if (m_valid !== 1'b1 || m_data !== DW'(18'h200)) begin
            fails++;
            $display("FAIL bp_hold[%0d]: m_valid=%b m_data=%h, required 1/200", c, m_valid, m_data);
         end
         @(negedge rclk);
      end
      // Two words fetched past the start pointer 129: read address 131 mod 128.
      tests++;
      if (rd_addr !== 7'd3) begin
         fails++;
         $display("FAIL bp_rd_addr: rd_addr=%h, required 3", rd_addr);
      end
      m_ready = 1'b1;
      consume(DW'(18'h200), 10, waited);
      tests++;
      if (waited != 0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL bp_release: waited=%0d idle=%b, required 0/1", waited, idle);
      end
   endtask

   task automatic test_wrap;
      int waited;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               push(DW'(18'h1000 + i));
               @(negedge rclk);
            end
         end
         begin
            consume(DW'(18'h1000), 300, waited);
         end
         begin
            logic [AW:0] prev;
            logic [AW:0] cur;
            prev = rd_ptr_out;
            for (int c = 0; c < 310; c++) begin
               @(negedge rclk);
               cur = rd_ptr_out;
               tests++;
`ifdef FIFO_RD_GRAY_EN
               if ($countones(cur ^ prev) > 1) begin
`else
               if ((cur - prev) > (AW+1)'(1)) begin
`endif
                  fails++;
                  $display("FAIL wrap_ptr_step[%0d]: %h -> %h", c, prev, cur);
               end
               prev = cur;
            end
         end
      join
      tests++;
      if (rd_ptr_out !== enc(8'd183) || idle !== 1'b1 || m_valid !== 1'b0) begin
         fails++;
         $display("FAIL wrap_end: rd_ptr_out=%h idle=%b m_valid=%b, required %h/1/0",
                  rd_ptr_out, idle, m_valid, enc(8'd183));
      end
   endtask

   task automatic test_reset_mid;
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(DW'(18'h3000 + i));
      repeat (2) @(negedge rclk);
      tests++;
      if (m_valid !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre: m_valid=%b, required 1", m_valid);
      end
      #2;
      rrst_n    = 1'b0;
      wptr      = '0;
      wr_ptr_in = '0;
      #1;
      tests++;
      if (m_valid !== 1'b0 || m_data !== '0 || rd_ptr_out !== '0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset: m_valid=%b m_data=%h rd_ptr_out=%h idle=%b, required 0/0/0/1",
                  m_valid, m_data, rd_ptr_out, idle);
      end
      @(negedge rclk);
      rrst_n  = 1'b1;
      m_ready = 1'b1;
      repeat (3) @(negedge rclk);
      tests++;
      if (m_valid !== 1'b0 || idle !== 1'b1 || rd_addr !== '0) begin
         fails++;
         $display("FAIL mid_release: m_valid=%b idle=%b rd_addr=%h, required 0/1/0",
                  m_valid, idle, rd_addr);
      end
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      test_reset();
      test_single();
      test_streaming();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
